// File: rtl/result_checker.sv
// Result checker: compares an observed CPU result stream against a DEPTH-entry expected table.
// Optional first-mismatch capture is enabled by defining RESULT_CHECKER_FIRST_ERR_EN.
module result_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             result_valid_i,
  input  logic             exp_we_i,
  input  logic [IW-1:0]    exp_addr_i,
  input  logic [WIDTH-1:0] exp_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [IW-1:0]    idx_o,
  output logic [7:0]       err_cnt_o,
  output logic             first_err_vld_o,
  output logic [IW-1:0]    first_err_idx_o,
  output logic [WIDTH-1:0] first_err_got_o,
  output logic [WIDTH-1:0] first_err_exp_o
);

  // state  | meaning
  // S_IDLE | waiting for start after reset
  // S_RUN  | comparing valid results against the table
  // S_PASS | run finished with zero mismatches
  // S_FAIL | run finished with at least one mismatch
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             clr;
  logic             cmp_en;
  logic             mism;
  logic [WIDTH-1:0] tbl_q [DEPTH];

  // Table is deliberately outside the reset domain so a reset keeps its contents.
  always_ff @(posedge clk_i) begin
    if (exp_we_i && (state_q != S_RUN)) begin
      tbl_q[exp_addr_i] <= exp_data_i;
    end
  end

  assign mism = (result_i != tbl_q[idx_q]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_cnt_d = err_cnt_q;
    clr       = 1'b0;
    cmp_en    = 1'b0;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start_i) begin
          state_d   = S_RUN;
          idx_d     = '0;
          err_cnt_d = '0;
          clr       = 1'b1;
        end
      end
      S_RUN: begin
        if (result_valid_i) begin
          cmp_en = 1'b1;
          if (mism && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (idx_q == IW'(DEPTH - 1)) begin
            idx_d   = '0;
            state_d = (err_cnt_d == 8'd0) ? S_PASS : S_FAIL;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef RESULT_CHECKER_FIRST_ERR_EN
  logic             fe_vld_q;
  logic [IW-1:0]    fe_idx_q;
  logic [WIDTH-1:0] fe_got_q;
  logic [WIDTH-1:0] fe_exp_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr) begin
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
      fe_got_q <= '0;
      fe_exp_q <= '0;
    end else if (cmp_en && mism && !fe_vld_q) begin
      fe_vld_q <= 1'b1;
      fe_idx_q <= idx_q;
      fe_got_q <= result_i;
      fe_exp_q <= tbl_q[idx_q];
    end
  end

  assign first_err_vld_o = fe_vld_q;
  assign first_err_idx_o = fe_idx_q;
  assign first_err_got_o = fe_got_q;
  assign first_err_exp_o = fe_exp_q;
`else
  assign first_err_vld_o = 1'b0;
  assign first_err_idx_o = '0;
  assign first_err_got_o = '0;
  assign first_err_exp_o = '0;
`endif

  assign busy_o    = (state_q == S_RUN);
  assign done_o    = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass_o    = (state_q == S_PASS);
  assign idx_o     = idx_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the observed CPU result word.
REQ-002 Parameter DEPTH, default 16, number of expected results checked per run; IW = clog2(DEPTH).
REQ-003 clk  input  1  rising-edge clock, same clock as the cpu core.
REQ-004 rst  input  1  reset; one clock, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse beginning a check run.
REQ-006 result  input  WIDTH  CPU Result bus under observation.
REQ-007 result_valid  input  1  result is meaningful this cycle.
REQ-008 exp_we  input  1  expected-table write enable.
REQ-009 exp_addr  input  IW  expected-table write index.
REQ-010 exp_data  input  WIDTH  expected-table write data.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high once a run has completed, held until next start or reset.
REQ-013 pass  output  1  high with done when no mismatches occurred.
REQ-014 idx  output  IW  index of the next expected entry to compare.
REQ-015 err_cnt  output  8  mismatch count, saturating at 255.
REQ-016 first_err_vld / first_err_idx / first_err_got / first_err_exp  output  1 / IW / WIDTH / WIDTH  first-mismatch capture.

Function
REQ-017 FSM states: IDLE, RUN, PASS, FAIL; exactly one active.
REQ-018 IDLE: start=1 -> RUN next cycle; idx, err_cnt, first_err_* cleared at that edge.
REQ-019 RUN: on each cycle with result_valid=1, compare result against table[idx] as signed-agnostic bitwise equality; idx increments by 1.
REQ-020 RUN: result_valid=0 -> no compare, idx and err_cnt hold; no timeout.
REQ-021 Mismatch -> err_cnt+1 (saturate at 255, no wrap); if first_err_vld=0, capture idx, result, table[idx], set first_err_vld.
REQ-022 Compare at idx=DEPTH-1 -> next state PASS if resulting err_cnt=0, else FAIL; idx wraps to 0.
REQ-023 PASS/FAIL: done=1, busy=0, pass=1 only in PASS; compares stop; start=1 -> RUN with counters cleared as in REQ-018.
REQ-024 busy=1 exactly in RUN; start while RUN ignored.
REQ-025 exp_we accepted in IDLE, PASS, FAIL (write at clock edge); ignored in RUN.
REQ-026 exp_we and start in same IDLE cycle: write lands that edge; first compare uses new value.
REQ-027 Outputs registered; response to a compare visible the cycle after the sampling edge.

Reset
REQ-028 rst=0 sampled at rising edge -> IDLE; busy=0, done=0, pass=0, idx=0, err_cnt=0, first_err_* = 0.
REQ-029 Reset mid-run abandons the run; expected table contents are not cleared by reset.

Configuration
REQ-030 Macro RESULT_CHECKER_FIRST_ERR_EN: defined -> first-mismatch capture per REQ-021 implemented.
REQ-031 Not defined -> first_err_* ports remain present and are tied to 0; all other behaviour identical.

Verification
REQ-032 Load table 0..15 with k*3; start; drive result=k*3 valid each cycle -> busy 16 cycles, then done=1, pass=1, err_cnt=0.
REQ-033 Same table; drive result=-7 (32'hFFFFFFF9) at idx 5 and 9 -> FAIL, err_cnt=2, first_err_idx=5, first_err_got=32'hFFFFFFF9, first_err_exp=15.
REQ-034 Valid gaps: deassert result_valid 3 cycles after idx 4 -> idx holds at 5, run ends after 16 valid compares, pass=1.
REQ-035 All 16 mismatch across 20 back-to-back runs without table reload -> err_cnt never exceeds 255; restart clears to 0; exp_we during RUN leaves table unchanged.
REQ-036 rst=0 at idx 7 -> next cycle IDLE, all outputs 0; restart without reload -> pass=1 using retained table.
REQ-037 Build without RESULT_CHECKER_FIRST_ERR_EN, rerun REQ-033 -> err_cnt=2, FAIL, first_err_* all 0.
